// File: rtl/branch_flow_ctrl.sv
// branch_flow_ctrl: ID-stage branch hazard stall, taken-branch redirect and exception flush sequencing
module branch_flow_ctrl #(
    parameter int EXC_FLUSH_CYCLES = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ctrl_insn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             is_branch,
    input  logic [31:0]      target_pc,
    input  logic             ex_wreg,
    input  logic [4:0]       ex_waddr,
    input  logic             mem_wreg,
    input  logic [4:0]       mem_waddr,
    input  logic             mem_is_load,
    input  logic             exception,
    input  logic [31:0]      exc_vector,
    input  logic             cnt_clr,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_idex,
    output logic             flush_ifid,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, REDIRECT = 2'd2, EXC_FLUSH = 2'd3} state_t;
    state_t state;
    logic [3:0] exc_cnt;
    logic exc_idex, ex_hz, mem_hz, hz_stall, go_exc, go_redir;
    // A non-load MEM result is forwarded, so only loads in MEM block the compare
    assign ex_hz = ex_wreg && ex_waddr != 5'd0 && (ex_waddr == id_rs || (id_uses_rt && ex_waddr == id_rt));
    assign mem_hz = mem_wreg && mem_is_load && mem_waddr != 5'd0 &&
                    (mem_waddr == id_rs || (id_uses_rt && mem_waddr == id_rt));
    assign hz_stall = id_ctrl_insn && (ex_hz || mem_hz) && !exception && (state == IDLE || state == STALL);
    assign go_exc = exception && state != EXC_FLUSH;
    assign go_redir = !go_exc && !hz_stall && is_branch && (state == STALL || (state == IDLE && id_ctrl_insn));
    assign stall_pc = hz_stall;
    assign stall_ifid = hz_stall;
    assign flush_idex = hz_stall || exc_idex;
    assign state_o = state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            exc_cnt <= '0;
            redirect_pc <= '0;
            redirect_valid <= 1'b0;
            flush_ifid <= 1'b0;
            exc_idex <= 1'b0;
        end else begin
            redirect_valid <= go_exc || go_redir;
            flush_ifid <= go_exc || go_redir;
            exc_idex <= go_exc;
            if (go_exc) begin
                state <= EXC_FLUSH;
                redirect_pc <= exc_vector;
                exc_cnt <= 4'(EXC_FLUSH_CYCLES - 1);
            end else if (go_redir) begin
                state <= REDIRECT;
                redirect_pc <= target_pc;
            end else if (hz_stall)
                state <= STALL;
            else if (state == EXC_FLUSH && exc_cnt != 4'd0)
                exc_cnt <= exc_cnt - 1'b1;
            else
                state <= IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (hz_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (go_redir && !(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_flow_ctrl.sv
// tb_branch_flow_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_branch_flow_ctrl;
    localparam int N = 2;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0, rst;
    logic id_ctrl_insn, id_uses_rt, is_branch, ex_wreg, mem_wreg, mem_is_load, exception, cnt_clr;
    logic [4:0] id_rs, id_rt, ex_waddr, mem_waddr;
    logic [31:0] target_pc, exc_vector, redirect_pc;
    logic stall_pc, stall_ifid, flush_idex, flush_ifid, redirect_valid;
    logic [1:0] state_o;
    logic [CW-1:0] taken_cnt, stall_cnt;
    logic [6:0] ctl;
    int passed = 0, total = 0;

    branch_flow_ctrl #(.EXC_FLUSH_CYCLES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_ctrl_insn(id_ctrl_insn), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .is_branch(is_branch), .target_pc(target_pc), .ex_wreg(ex_wreg),
        .ex_waddr(ex_waddr), .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_is_load(mem_is_load),
        .exception(exception), .exc_vector(exc_vector), .cnt_clr(cnt_clr), .stall_pc(stall_pc),
        .stall_ifid(stall_ifid), .flush_idex(flush_idex), .flush_ifid(flush_ifid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .state_o(state_o),
        .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    // {stall_pc, stall_ifid, flush_idex, flush_ifid, redirect_valid, state_o}
    assign ctl = {stall_pc, stall_ifid, flush_idex, flush_ifid, redirect_valid, state_o};
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        id_ctrl_insn = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; is_branch = 0; target_pc = 0;
        ex_wreg = 0; ex_waddr = 0; mem_wreg = 0; mem_waddr = 0; mem_is_load = 0;
        exception = 0; exc_vector = 0; cnt_clr = 0;
    endtask

    function automatic bit hz_ref(input bit ins_rt, input [4:0] rs, input [4:0] rt, input bit ew,
                                  input [4:0] ea, input bit mw, input [4:0] ma, input bit ml);
        bit r = 0;
        if (ew && ea != 0 && ea == rs) r = 1;
        if (ew && ins_rt && ea != 0 && ea == rt) r = 1;
        if (mw && ml && ma != 0 && (ma == rs || (ins_rt && ma == rt))) r = 1;
        return r;
    endfunction

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        #3;
        total++; if (ctl !== 7'b0) $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0); else passed++;
        total++; if ({redirect_pc, taken_cnt, stall_cnt} !== '0)
            $display("FAIL reset_regs: got pc=%h taken=%0d stall=%0d want 0", redirect_pc, taken_cnt, stall_cnt);
        else passed++;
        tick(); tick();
        rst = 0;
        #1;
        total++; if (ctl !== 7'b0) $display("FAIL reset_release: got %b want %b", ctl, 7'b0); else passed++;
    endtask

    task automatic test_redirect;
        tick();
        id_ctrl_insn = 1; id_rs = 1; id_rt = 2; id_uses_rt = 1; is_branch = 1; target_pc = 32'h0040_0020;
        #1;
        total++; if (ctl !== 7'b0) $display("FAIL redir_resolve: got %b want %b", ctl, 7'b0); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (ctl !== 7'b0001110) $display("FAIL redir_ctl: got %b want %b", ctl, 7'b0001110); else passed++;
        total++; if (redirect_pc !== 32'h0040_0020 || taken_cnt !== 1)
            $display("FAIL redir_pc: got pc=%h taken=%0d want 00400020 1", redirect_pc, taken_cnt);
        else passed++;
        tick();
        #1;
        total++; if (ctl !== 7'b0 || taken_cnt !== 1)
            $display("FAIL redir_done: got %b taken=%0d want 0000000 1", ctl, taken_cnt);
        else passed++;
    endtask

    task automatic test_ex_stall;
        tick();
        ex_wreg = 1; ex_waddr = 8; id_ctrl_insn = 1; id_rs = 8; id_rt = 0; id_uses_rt = 1; is_branch = 0;
        #1;
        total++; if (ctl !== 7'b1110000) $display("FAIL ex_stall: got %b want %b", ctl, 7'b1110000); else passed++;
        tick();
        ex_wreg = 0;
        #1;
        total++; if (ctl !== 7'b0000001 || stall_cnt !== 1)
            $display("FAIL ex_stall_clear: got %b cnt=%0d want 0000001 1", ctl, stall_cnt);
        else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (ctl !== 7'b0 || taken_cnt !== 1)
            $display("FAIL ex_stall_idle: got %b taken=%0d want 0000000 1", ctl, taken_cnt);
        else passed++;
    endtask

    task automatic test_load_hazard;
        tick();
        mem_wreg = 1; mem_is_load = 1; mem_waddr = 9;
        id_ctrl_insn = 1; id_rs = 3; id_rt = 9; id_uses_rt = 1; is_branch = 0;
        #1;
        total++; if (ctl !== 7'b1110000) $display("FAIL load_stall: got %b want %b", ctl, 7'b1110000); else passed++;
        tick();
        mem_wreg = 0;
        #1;
        total++; if (ctl !== 7'b0000001 || stall_cnt !== 2)
            $display("FAIL load_clear: got %b cnt=%0d want 0000001 2", ctl, stall_cnt);
        else passed++;
        tick();
        mem_wreg = 1; id_uses_rt = 0;
        #1;
        total++; if (ctl !== 7'b0) $display("FAIL load_no_rt: got %b want %b", ctl, 7'b0); else passed++;
        mem_is_load = 0; id_rs = 9;
        #1;
        total++; if (ctl !== 7'b0) $display("FAIL mem_forward: got %b want %b", ctl, 7'b0); else passed++;
        mem_wreg = 0; ex_wreg = 1; ex_waddr = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
        #1;
        total++; if (ctl !== 7'b0) $display("FAIL reg_zero: got %b want %b", ctl, 7'b0); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (ctl !== 7'b0 || stall_cnt !== 2)
            $display("FAIL load_idle: got %b cnt=%0d want 0000000 2", ctl, stall_cnt);
        else passed++;
    endtask

    task automatic test_exception;
        tick();
        ex_wreg = 1; ex_waddr = 8; id_ctrl_insn = 1; id_rs = 8; is_branch = 1; target_pc = 32'h0000_0800;
        exception = 1; exc_vector = 32'h0000_0004;
        #1;
        total++; if (ctl !== 7'b0) $display("FAIL exc_no_stall: got %b want %b", ctl, 7'b0); else passed++;
        tick();
        exception = 0;
        #1;
        total++; if (ctl !== 7'b0011111 || redirect_pc !== 32'h4)
            $display("FAIL exc_first: got %b pc=%h want 0011111 00000004", ctl, redirect_pc);
        else passed++;
        tick();
        exception = 1; exc_vector = 32'h0000_0100;
        #1;
        total++; if (ctl !== 7'b0000011) $display("FAIL exc_second: got %b want %b", ctl, 7'b0000011); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (ctl !== 7'b0 || redirect_pc !== 32'h4 || stall_cnt !== 2)
            $display("FAIL exc_exit: got %b pc=%h cnt=%0d want 0000000 00000004 2", ctl, redirect_pc, stall_cnt);
        else passed++;
    endtask

    task automatic test_saturate_and_reset;
        tick();
        ex_wreg = 1; ex_waddr = 8; id_ctrl_insn = 1; id_rs = 8; is_branch = 0;
        for (int i = 0; i < 260; i++) tick();
        #1;
        total++; if (ctl !== 7'b1110001 || stall_cnt !== CW'(CMAX))
            $display("FAIL stall_sat: got %b cnt=%0d want 1110001 %0d", ctl, stall_cnt, CMAX);
        else passed++;
        cnt_clr = 1;
        tick();
        cnt_clr = 0; ex_wreg = 0; is_branch = 1; target_pc = 32'h0000_1234;
        #1;
        total++; if (stall_cnt !== 0 || taken_cnt !== 0)
            $display("FAIL cnt_clr: got stall=%0d taken=%0d want 0 0", stall_cnt, taken_cnt);
        else passed++;
        total++; if (ctl !== 7'b0000001) $display("FAIL stall_to_redir: got %b want %b", ctl, 7'b0000001); else passed++;
        tick();
        idle_inputs();
        #1;
        total++; if (ctl !== 7'b0001110 || redirect_pc !== 32'h1234 || taken_cnt !== 1)
            $display("FAIL stall_redir: got %b pc=%h taken=%0d want 0001110 00001234 1", ctl, redirect_pc, taken_cnt);
        else passed++;
        rst = 1;
        #1;
        total++; if (ctl !== 7'b0 || redirect_pc !== 0 || taken_cnt !== 0)
            $display("FAIL mid_reset: got %b pc=%h taken=%0d want 0000000 0 0", ctl, redirect_pc, taken_cnt);
        else passed++;
        tick();
        rst = 0;
    endtask

    task automatic test_random;
        bit stalled = 0, redir = 0, cur, first, tinc;
        int flush_left = 0, m_taken = 0, m_stall = 0, errs = 0;
        logic [31:0] m_pc = 0;
        logic [1:0] st;
        logic [6:0] exp;
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            id_ctrl_insn = $urandom_range(0, 3) != 0; id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3)); id_uses_rt = 1'($urandom); is_branch = 1'($urandom);
            target_pc = $urandom; ex_wreg = 1'($urandom); ex_waddr = 5'($urandom_range(0, 3));
            mem_wreg = 1'($urandom); mem_waddr = 5'($urandom_range(0, 3)); mem_is_load = 1'($urandom);
            exception = $urandom_range(0, 15) == 0; exc_vector = $urandom; cnt_clr = $urandom_range(0, 63) == 0;
            #1;
            cur = id_ctrl_insn && !exception && flush_left == 0 && !redir &&
                  hz_ref(id_uses_rt, id_rs, id_rt, ex_wreg, ex_waddr, mem_wreg, mem_waddr, mem_is_load);
            first = flush_left == N;
            st = flush_left > 0 ? 2'd3 : redir ? 2'd2 : stalled ? 2'd1 : 2'd0;
            exp = {cur, cur, cur | first, redir | first, redir | first, st};
            total++;
            if (ctl !== exp) begin
                if (errs < 10) $display("FAIL rand_ctl cycle %0d: got %b want %b", i, ctl, exp);
                errs++;
            end else passed++;
            total++;
            if (redirect_pc !== m_pc || taken_cnt !== CW'(m_taken) || stall_cnt !== CW'(m_stall)) begin
                if (errs < 10) $display("FAIL rand_regs cycle %0d: got pc=%h taken=%0d stall=%0d want %h %0d %0d",
                                        i, redirect_pc, taken_cnt, stall_cnt, m_pc, m_taken, m_stall);
                errs++;
            end else passed++;
            tinc = 0;
            if (flush_left > 0) flush_left--;
            else if (exception) begin flush_left = N; m_pc = exc_vector; redir = 0; stalled = 0; end
            else if (cur) stalled = 1;
            else if (redir) redir = 0;
            else if (is_branch && (stalled || id_ctrl_insn)) begin redir = 1; m_pc = target_pc; stalled = 0; tinc = 1; end
            else stalled = 0;
            if (cnt_clr) begin m_taken = 0; m_stall = 0; end
            else begin
                if (cur && m_stall < CMAX) m_stall++;
                if (tinc && m_taken < CMAX) m_taken++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_ex_stall();
        test_load_hazard();
        test_exception();
        test_saturate_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
